rdma_tx_header_inserter: RTL

//   Downstream of the DDR MM2S read/segmenter stage in the TX path. Takes per-message

---
 rtl/rdma_tx_header_inserter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rdma_tx_header_inserter.sv
// RDMA TX header inserter.
// Prepends one RDMA header beat (opcode, 24-bit PSN, remote address) to each
// payload segment coming from the segmenter, then passes the segment through
// with no added latency. One msg_done pulse is raised per message.
//
// Handshake rule for all three streams (meta, s_axis, m_axis): a transfer
// happens on a rising clk edge where valid and ready are both high; a source
// holds its valid and data stable until that edge, and ready never waits on
// anything but the consumer's own state.
module rdma_tx_header_inserter #(
  parameter int DATA_W        = 64,
  parameter int MAX_SEG_BEATS = 8,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] meta_dst_addr,
  input  logic [31:0]       meta_length,
  input  logic              meta_valid,
  output logic              meta_ready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              msg_done,
  output logic [1:0]        dbg_state
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int SEG_BYTES  = MAX_SEG_BEATS * BEAT_BYTES;

  localparam logic [31:0]       BEAT_BYTES_W = 32'(BEAT_BYTES);
  localparam logic [31:0]       SEG_BYTES_W  = 32'(SEG_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_STEP    = ADDR_W'(BEAT_BYTES);

  localparam logic [7:0] OP_FIRST  = 8'h00;
  localparam logic [7:0] OP_MIDDLE = 8'h01;
  localparam logic [7:0] OP_LAST   = 8'h02;
  localparam logic [7:0] OP_ONLY   = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rem_q, rem_d;
  logic              first_q, first_d;
  logic [23:0]       psn_q, psn_d;

  logic [31:0]       addr_lo;
  logic [7:0]        opcode;
  logic [DATA_W-1:0] hdr_word;
  logic [31:0]       rem_dec;

  // Low 32 address bits for the header; narrower addresses are zero-extended.
  generate
    if (ADDR_W >= 32) begin : g_addr_wide
      assign addr_lo = addr_q[31:0];
    end else begin : g_addr_narrow
      assign addr_lo = {{(32 - ADDR_W){1'b0}}, addr_q};
    end
  endgenerate

  // Remaining-byte count after one payload beat, floored at zero so a short
  // final beat cannot wrap the counter.
  assign rem_dec = (rem_q > BEAT_BYTES_W) ? (rem_q - BEAT_BYTES_W) : 32'd0;

  // Opcode from position in the message: does this segment finish it, and is it the first.
  always_comb begin
    opcode = OP_MIDDLE;
    if (rem_q <= SEG_BYTES_W) begin
      opcode = first_q ? OP_ONLY : OP_LAST;
    end else begin
      opcode = first_q ? OP_FIRST : OP_MIDDLE;
    end
  end

  // Header beat layout: opcode[63:56], psn[55:32], addr[31:0], zero above bit 63.
  always_comb begin
    hdr_word        = '0;
    hdr_word[63:56] = opcode;
    hdr_word[55:32] = psn_q;
    hdr_word[31:0]  = addr_lo;
  end

  // Next-state and output decode for the header/payload sequencer.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    first_d       = first_q;
    psn_d         = psn_q;
    meta_ready    = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    msg_done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Held low while rst is asserted even though the state is already IDLE.
        meta_ready = !rst;
        if (meta_valid && !rst) begin
          addr_d  = meta_dst_addr;
          rem_d   = meta_length;
          first_d = 1'b1;
          state_d = (meta_length == 32'd0) ? S_DONE : S_HDR;
        end
      end

      S_HDR: begin
        m_axis_tdata  = hdr_word;
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          psn_d   = psn_q + 24'd1;
          first_d = 1'b0;
          state_d = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          addr_d = addr_q + ADDR_STEP;
          rem_d  = rem_dec;
          // The segmenter's tlast closes the packet; an early zero count does not.
          if (s_axis_tlast) begin
            state_d = (rem_dec == 32'd0) ? S_DONE : S_HDR;
          end
        end
      end

      S_DONE: begin
        msg_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      psn_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      psn_q   <= psn_d;
    end
  end

  assign dbg_state = state_q;

endmodule
